// File: rtl/mem_model_if.sv
// Request/response bus of the memory model: one request channel and one
// response channel, each with its own valid/ready handshake.
interface mem_model_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, addr, wdata, wstrb, rsp_ready,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, addr, wdata, wstrb, rsp_ready,
    output req_ready, rsp_valid, rdata, rsp_err
  );
endinterface

// File: rtl/mem_model.sv
// Single-outstanding word memory with byte strobes and a fixed response latency.
// Define MEM_MODEL_PRELOAD_EN to initialise word i to value i at time zero.
module mem_model #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_model_if.slave   bus
);

  localparam int              STRB_W   = DATA_W / 8;
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAT_LOAD = 4'(RD_LAT - 1);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_chk_data_w
    $error("mem_model: DATA_W must be a positive multiple of 8");
  end
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_chk_rd_lat
    $error("mem_model: RD_LAT must be within 1..15");
  end
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_chk_depth
    $error("mem_model: DEPTH must be within 1..2**ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rdata;

`ifdef MEM_MODEL_PRELOAD_EN
  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t preload_image();
    mem_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = DATA_W'(i);
    end
    return img;
  endfunction

  mem_t r_mem = preload_image();
`else
  logic [DATA_W-1:0]   r_mem [DEPTH];
`endif

  logic                w_accept;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_rd_word;

  assign w_accept   = rst_n && bus.req_valid && r_req_ready;
  assign w_in_range = ({1'b0, bus.addr} < DEPTH_C);
  assign w_idx      = bus.addr[IDX_W-1:0];
  assign w_rd_word  = r_mem[w_idx];

  // Writes commit at the accept edge; out-of-range addresses never touch the array.
  always_ff @(posedge clk) begin
    if (w_accept && bus.req_write && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_WAIT;
            r_req_ready <= 1'b0;
            r_cnt       <= LAT_LOAD;
            r_rsp_err   <= !w_in_range;
            r_rdata     <= (!bus.req_write && w_in_range) ? w_rd_word : '0;
          end
        end
        S_WAIT: begin
          // Count reaching zero here puts rsp_valid up exactly RD_LAT edges after accept.
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rdata     = r_rdata;

endmodule
